// File: rtl/fft_chk_pkg.sv
// Shared types and helpers for the streaming FFT output checker.
package fft_chk_pkg;

  // Widest sample component the difference helper supports (W must be < MaxW).
  localparam int unsigned MaxW = 32;

  typedef enum logic [2:0] {
    ErrNone      = 3'd0,
    ErrReal      = 3'd1,
    ErrImag      = 3'd2,
    ErrStart     = 3'd3,
    ErrOverflow  = 3'd4,
    ErrUnderflow = 3'd5,
    ErrTimeout   = 3'd6,
    ErrUnexpStart = 3'd7
  } err_e;

  typedef enum logic [0:0] {
    StIdle,
    StFrame
  } state_e;

  // |a - b| of two sign-extended operands, one bit wider so the difference never wraps.
  function automatic logic [MaxW:0] abs_diff(input logic [MaxW-1:0] a, input logic [MaxW-1:0] b);
    logic [MaxW:0] d;
    d = {a[MaxW-1], a} - {b[MaxW-1], b};
    abs_diff = d[MaxW] ? (~d + {{MaxW{1'b0}}, 1'b1}) : d;
  endfunction

endpackage

// File: rtl/fft_stream_checker_if.sv
// Expected-sample push port plus the monitored FFT output stream.
interface fft_stream_checker_if #(
  parameter int unsigned W = 20
) ();
  logic         exp_valid;
  logic [W-1:0] exp_real;
  logic [W-1:0] exp_imag;
  logic         exp_ready;
  logic [W-1:0] realout;
  logic [W-1:0] imagout;
  logic         startout;

  modport master (
    output exp_valid, exp_real, exp_imag, realout, imagout, startout,
    input  exp_ready
  );

  modport slave (
    input  exp_valid, exp_real, exp_imag, realout, imagout, startout,
    output exp_ready
  );
endinterface

// File: rtl/fft_exp_fifo.sv
// Synchronous FIFO of expected samples; head is read straight from the storage flops.
module fft_exp_fifo #(
  parameter int unsigned WIDTH = 41,
  parameter int unsigned DEPTH = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // Pointer/count next state; a push while full is accepted only if a pop frees the slot.
  always_comb begin
    do_pop   = pop_i && !empty_o;
    do_push  = push_i && (!full_o || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer state; reset empties the FIFO without touching storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Sample storage write.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/fft_stream_checker.sv
// Frames a streaming FFT output on its start pulse and checks every sample against a FIFO
// of expected values within a tolerance, with sticky error status and a no-output timeout.
module fft_stream_checker
  import fft_chk_pkg::*;
#(
  parameter int unsigned W       = 20,
  parameter int unsigned N       = 256,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned TOL     = 3,
  parameter int unsigned TIMEOUT = 2000
) (
  input  logic                 clk,
  input  logic                 reset,
  fft_stream_checker_if.slave  bus,
  output logic                 in_frame,
  output logic                 err_flag,
  output logic [2:0]           err_code,
  output logic [15:0]          mismatch_cnt,
  output logic [15:0]          frames_ok,
  output logic                 timeout
);
  localparam int unsigned IW = $clog2(N);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned FW = 2 * W + 1;

  logic [FW-1:0] head;
  logic          head_start;
  logic [W-1:0]  head_re, head_im;
  logic          fifo_full, fifo_empty;

  state_e        state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] push_idx_q, push_idx_d;
  logic          pop, first, last;
  logic          ev_overflow, ev_underflow, ev_unexp, ev_tmo;
  logic          fail_re, fail_im, fail_st;

  // Compare results, registered one cycle ahead of the status they feed.
  logic          fail_re_q, fail_im_q, fail_st_q, first_q, last_q;
  logic          any_fail_q, frame_err_now;

  logic          frame_err_q, frame_err_d;
  logic          err_flag_q, err_flag_d;
  err_e          err_code_q, err_code_d, new_code;
  logic [15:0]   mm_q, mm_d;
  logic [15:0]   fok_q, fok_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          timeout_q, timeout_d;

  assign {head_start, head_re, head_im} = head;

  fft_exp_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (bus.exp_valid),
    .data_i  ({push_idx_q == '0, bus.exp_real, bus.exp_imag}),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bus.exp_ready = !fifo_full;
  assign in_frame      = (state_q == StFrame);
  assign err_flag      = err_flag_q;
  assign err_code      = err_code_q;
  assign mismatch_cnt  = mm_q;
  assign frames_ok     = fok_q;
  assign timeout       = timeout_q;

  // Push index advances only on accepted pushes; a dropped push is an overflow.
  always_comb begin
    ev_overflow = bus.exp_valid && fifo_full && !pop;
    push_idx_d  = (bus.exp_valid && !ev_overflow) ? push_idx_q + IW'(1) : push_idx_q;
  end

  // Framing FSM next state: decides when the head is compared and popped.
  always_comb begin
    pop          = 1'b0;
    first        = 1'b0;
    last         = 1'b0;
    ev_underflow = 1'b0;
    ev_unexp     = 1'b0;
    state_d      = state_q;
    cnt_d        = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.startout) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            first   = 1'b1;
            cnt_d   = IW'(1);
            state_d = StFrame;
          end else begin
            ev_unexp = 1'b1;
          end
        end
      end
      StFrame: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (cnt_q == IW'(N - 1)) begin
            last    = 1'b1;
            cnt_d   = '0;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + IW'(1);
          end
        end else begin
          ev_underflow = 1'b1;
          cnt_d        = '0;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Per-sample tolerance and framing checks against the FIFO head.
  always_comb begin
    fail_re = pop && (abs_diff({{(MaxW-W){bus.realout[W-1]}}, bus.realout},
                               {{(MaxW-W){head_re[W-1]}}, head_re}) > (MaxW+1)'(TOL));
    fail_im = pop && (abs_diff({{(MaxW-W){bus.imagout[W-1]}}, bus.imagout},
                               {{(MaxW-W){head_im[W-1]}}, head_im}) > (MaxW+1)'(TOL));
    fail_st = pop && (bus.startout != head_start);
  end

  // Timeout counter: reloads on every compare, counts down while expected data waits.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    ev_tmo    = 1'b0;
    if (pop) begin
      tmo_cnt_d = TW'(TIMEOUT);
    end else if (!fifo_empty && tmo_cnt_q != '0) begin
      tmo_cnt_d = tmo_cnt_q - TW'(1);
      ev_tmo    = (tmo_cnt_q == TW'(1));
    end
    timeout_d = timeout_q | ev_tmo;
  end

  // Status update: registered compare results plus this cycle's direct events.
  always_comb begin
    any_fail_q    = fail_re_q | fail_im_q | fail_st_q;
    frame_err_now = (first_q ? 1'b0 : frame_err_q) | any_fail_q;
    frame_err_d   = frame_err_now;
    fok_d         = (last_q && !frame_err_now) ? fok_q + 16'd1 : fok_q;
    mm_d          = (any_fail_q && mm_q != 16'hFFFF) ? mm_q + 16'd1 : mm_q;

    new_code = ErrNone;
    if (fail_re_q)         new_code = ErrReal;
    else if (fail_im_q)    new_code = ErrImag;
    else if (fail_st_q)    new_code = ErrStart;
    else if (ev_overflow)  new_code = ErrOverflow;
    else if (ev_underflow) new_code = ErrUnderflow;
    else if (ev_tmo)       new_code = ErrTimeout;
    else if (ev_unexp)     new_code = ErrUnexpStart;

    err_flag_d = err_flag_q | (new_code != ErrNone);
    err_code_d = (!err_flag_q && new_code != ErrNone) ? new_code : err_code_q;
  end

  // All checker state, including the FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      push_idx_q  <= '0;
      fail_re_q   <= 1'b0;
      fail_im_q   <= 1'b0;
      fail_st_q   <= 1'b0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      frame_err_q <= 1'b0;
      err_flag_q  <= 1'b0;
      err_code_q  <= ErrNone;
      mm_q        <= '0;
      fok_q       <= '0;
      tmo_cnt_q   <= TW'(TIMEOUT);
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      push_idx_q  <= push_idx_d;
      fail_re_q   <= fail_re;
      fail_im_q   <= fail_im;
      fail_st_q   <= fail_st;
      first_q     <= first;
      last_q      <= last;
      frame_err_q <= frame_err_d;
      err_flag_q  <= err_flag_d;
      err_code_q  <= err_code_d;
      mm_q        <= mm_d;
      fok_q       <= fok_d;
      tmo_cnt_q   <= tmo_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

endmodule

// File: tb/tb_fft_stream_checker.sv
// Self-checking bench for fft_stream_checker with a queue of expected status snapshots.
module tb_fft_stream_checker;
  localparam int W       = 20;
  localparam int N       = 8;
  localparam int DEPTH   = 16;
  localparam int TOL     = 3;
  localparam int TIMEOUT = 50;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_frame, err_flag, timeout;
  logic [2:0]  err_code;
  logic [15:0] mismatch_cnt, frames_ok;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic        ef;
    logic [2:0]  ec;
    logic [15:0] mm;
    logic [15:0] fok;
    logic        tmo;
  } exp_t;
  exp_t sb_q[$];

  logic [W-1:0] b_er [8];
  logic [W-1:0] b_ei [8];
  logic [W-1:0] b_gr [8];
  logic [W-1:0] b_gi [8];

  fft_stream_checker_if #(.W(W)) bus ();

  fft_stream_checker #(
    .W       (W),
    .N       (N),
    .DEPTH   (DEPTH),
    .TOL     (TOL),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .in_frame     (in_frame),
    .err_flag     (err_flag),
    .err_code     (err_code),
    .mismatch_cnt (mismatch_cnt),
    .frames_ok    (frames_ok),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_status(input string tag, input logic ef, input logic [2:0] ec,
                               input logic [15:0] mm, input logic [15:0] fok, input logic tmo);
    exp_t e;
    e.tag = tag; e.ef = ef; e.ec = ec; e.mm = mm; e.fok = fok; e.tmo = tmo;
    sb_q.push_back(e);
  endtask

  task automatic check_status();
    exp_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL sb_underrun: no expected status queued");
      return;
    end
    e = sb_q.pop_front();
    check_val({e.tag, "_err_flag"}, 32'(err_flag), 32'(e.ef));
    check_val({e.tag, "_err_code"}, 32'(err_code), 32'(e.ec));
    check_val({e.tag, "_mismatch"}, 32'(mismatch_cnt), 32'(e.mm));
    check_val({e.tag, "_frames_ok"}, 32'(frames_ok), 32'(e.fok));
    check_val({e.tag, "_timeout"}, 32'(timeout), 32'(e.tmo));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.startout = 1'b0;
    bus.realout  = '0;
    bus.imagout  = '0;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    bus.exp_valid = 1'b0;
    bus.exp_real  = '0;
    bus.exp_imag  = '0;
    drive_idle();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic push_sample(input logic [W-1:0] r, input logic [W-1:0] i);
    bus.exp_valid = 1'b1;
    bus.exp_real  = r;
    bus.exp_imag  = i;
    tick();
    bus.exp_valid = 1'b0;
  endtask

  task automatic push_ramp();
    for (int k = 0; k < N; k++) push_sample(W'(k), W'(-k));
  endtask

  // Drives samples from..to of the (k, -k) ramp; one sample may be offset, one extra start.
  task automatic stream_range(input int from, input int to, input int bad_idx, input int delta,
                              input int extra_start);
    for (int k = from; k <= to; k++) begin
      bus.startout = (k == 0) || (k == extra_start);
      bus.realout  = W'(k + ((k == bad_idx) ? delta : 0));
      bus.imagout  = W'(-k);
      tick();
      if (k == 0) check_val("in_frame_after_start", 32'(in_frame), 32'd1);
    end
    drive_idle();
  endtask

  task automatic stream_ramp(input int bad_idx, input int delta, input int extra_start);
    stream_range(0, N - 1, bad_idx, delta, extra_start);
    tick();
    tick();
    check_val("in_frame_after_frame", 32'(in_frame), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    b_er = '{20'h7FFFF, 20'hFFFFD, 20'h80002, 20'h0, 20'h0, 20'h7FFFF, 20'h0, 20'h0};
    b_ei = '{20'h0, 20'h0, 20'h0, 20'h0, 20'h00003, 20'h0, 20'h0, 20'h0};
    b_gr = '{20'h80000, 20'h0, 20'h7FFFF, 20'h0, 20'h0, 20'h7FFFC, 20'h0, 20'h0};
    b_gi = '{20'h0, 20'h0, 20'h0, 20'hFFFFC, 20'h0, 20'h0, 20'h0, 20'h0};

    // Clean frame.
    do_reset();
    check_val("reset_in_frame", 32'(in_frame), 32'd0);
    check_val("reset_exp_ready", 32'(bus.exp_ready), 32'd1);
    expect_status("reset", 1'b0, 3'd0, 16'd0, 16'd0, 1'b0);
    check_status();
    push_ramp();
    stream_ramp(-1, 0, -1);
    expect_status("clean", 1'b0, 3'd0, 16'd0, 16'd1, 1'b0);
    check_status();

    // Real part off by TOL+1 on sample 5, then a good frame.
    do_reset();
    push_ramp();
    stream_ramp(5, 4, -1);
    expect_status("bad_real", 1'b1, 3'd1, 16'd1, 16'd0, 1'b0);
    check_status();
    push_ramp();
    stream_ramp(-1, 0, -1);
    expect_status("good_after_bad", 1'b1, 3'd1, 16'd1, 16'd1, 1'b0);
    check_status();

    // Full-scale boundaries: no wrap, and a difference of exactly TOL passes.
    do_reset();
    for (int k = 0; k < N; k++) push_sample(b_er[k], b_ei[k]);
    for (int k = 0; k < N; k++) begin
      bus.startout = (k == 0);
      bus.realout  = b_gr[k];
      bus.imagout  = b_gi[k];
      tick();
    end
    drive_idle();
    tick();
    tick();
    expect_status("boundary", 1'b1, 3'd1, 16'd3, 16'd0, 1'b0);
    check_status();

    // Start with nothing expected.
    do_reset();
    bus.startout = 1'b1;
    tick();
    drive_idle();
    tick();
    check_val("unexp_in_frame", 32'(in_frame), 32'd0);
    expect_status("unexp_start", 1'b1, 3'd7, 16'd0, 16'd0, 1'b0);
    check_status();

    // Extra start pulse on sample 3.
    do_reset();
    push_ramp();
    stream_ramp(-1, 0, 3);
    expect_status("mid_start", 1'b1, 3'd3, 16'd1, 16'd0, 1'b0);
    check_status();

    // Overflow then timeout with the FFT silent.
    do_reset();
    for (int k = 0; k <= DEPTH; k++) begin
      bus.exp_valid = 1'b1;
      bus.exp_real  = W'(k);
      bus.exp_imag  = W'(-k);
      tick();
      if (k == DEPTH - 2) check_val("ready_before_full", 32'(bus.exp_ready), 32'd1);
      if (k == DEPTH - 1) check_val("ready_when_full", 32'(bus.exp_ready), 32'd0);
    end
    bus.exp_valid = 1'b0;
    check_val("overflow_code", 32'(err_code), 32'd4);
    for (int c = 0; c < TIMEOUT - DEPTH - 1; c++) tick();
    check_val("timeout_not_yet", 32'(timeout), 32'd0);
    tick();
    expect_status("timeout", 1'b1, 3'd4, 16'd0, 16'd0, 1'b1);
    check_status();

    // Reset in the middle of a frame.
    do_reset();
    push_ramp();
    stream_range(0, 3, 2, 4, -1);
    check_val("pre_reset_in_frame", 32'(in_frame), 32'd1);
    check_val("pre_reset_mismatch", 32'(mismatch_cnt), 32'd1);
    reset = 1'b1;
    tick();
    check_val("mid_reset_in_frame", 32'(in_frame), 32'd0);
    check_val("mid_reset_exp_ready", 32'(bus.exp_ready), 32'd1);
    expect_status("mid_reset", 1'b0, 3'd0, 16'd0, 16'd0, 1'b0);
    check_status();
    reset = 1'b0;
    bus.startout = 1'b1;
    tick();
    drive_idle();
    tick();
    check_val("post_reset_fifo_empty_in_frame", 32'(in_frame), 32'd0);
    expect_status("post_reset_empty", 1'b1, 3'd7, 16'd0, 16'd0, 1'b0);
    check_status();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
